hero_cmd_sched: RTL and testbench

- Command scheduler between the player input buttons and the hero movement controller.
- Edge-detects button presses, queues them in a small FIFO and issues them one at a time as single-cycle command pulses.
- Holds off the next pulse until the hero controller is known to be idle again, using fixed busy durations that match its move and attack step lengths.
- Adds type-ahead, pause (enable) and flush, so presses made mid-step are not lost.

---
 rtl/hero_cmd_sched.sv | 166 ++++++++++++++++
 tb/tb_hero_cmd_sched.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/hero_cmd_sched.sv
// rtl/hero_cmd_sched.sv - button-press command queue issuing one-cycle hero move/attack pulses
// Presses are edge-detected, queued, and released only once the previous hero step has finished.
module hero_cmd_sched #(
    parameter int DEPTH       = 4,
    parameter int MOVE_BUSY   = 62,
    parameter int ATTACK_BUSY = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     btn_up,
    input  logic                     btn_left,
    input  logic                     btn_right,
    input  logic                     btn_down,
    input  logic                     btn_center,
    input  logic                     enable,
    input  logic                     flush,
    output logic                     up,
    output logic                     left,
    output logic                     right,
    output logic                     down,
    output logic                     center,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
);

    localparam int PW   = $clog2(DEPTH);
    localparam int MAXB = (MOVE_BUSY > ATTACK_BUSY) ? MOVE_BUSY : ATTACK_BUSY;
    localparam int CW   = $clog2(MAXB);

    typedef enum logic [2:0] {
        CMD_UP     = 3'd0,
        CMD_LEFT   = 3'd1,
        CMD_RIGHT  = 3'd2,
        CMD_DOWN   = 3'd3,
        CMD_CENTER = 3'd4
    } cmd_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

    logic [4:0]    btn_vec;
    logic [4:0]    btn_q;
    logic [4:0]    press;
    cmd_e          push_cmd;
    logic          push;
    logic          push_ok;
    logic          pop;
    logic          can_pop;
    logic          full;
    logic [2:0]    head;

    logic [2:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    pulse_q, pulse_d;

    assign btn_vec = {btn_center, btn_down, btn_right, btn_left, btn_up};
    assign press   = btn_vec & ~btn_q;

    // Simultaneous presses collapse to the single highest-priority command
    always_comb begin
        push_cmd = CMD_UP;
        if (press[0])      push_cmd = CMD_UP;
        else if (press[1]) push_cmd = CMD_LEFT;
        else if (press[2]) push_cmd = CMD_RIGHT;
        else if (press[3]) push_cmd = CMD_DOWN;
        else if (press[4]) push_cmd = CMD_CENTER;
    end

    assign push    = enable & ~flush & (|press);
    assign full    = (count_q == (PW+1)'(DEPTH));
    assign can_pop = (state_q == S_IDLE) || ((state_q == S_WAIT) && (cnt_q == '0));
    assign pop     = can_pop && (count_q != '0) && enable && !flush;
    assign push_ok = push && (!full || pop);
    assign head    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + {{PW{1'b0}}, push_ok} - {{PW{1'b0}}, pop};
            if (push && full && !pop) ovf_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = '0;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    state_d = S_ISSUE;
                    pulse_d = 5'(1) << head;
                end
            end
            S_ISSUE: begin
                // Load BUSY-2 so the next pulse lands exactly BUSY cycles after this one
                state_d = S_WAIT;
                cnt_d   = pulse_q[CMD_CENTER] ? CW'(ATTACK_BUSY - 2) : CW'(MOVE_BUSY - 2);
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    if (pop) begin
                        state_d = S_ISSUE;
                        pulse_d = 5'(1) << head;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_cmd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            pulse_q  <= '0;
        end else begin
            btn_q    <= btn_vec;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pulse_q  <= pulse_d;
        end
    end

    assign {center, down, right, left, up} = pulse_q;
    assign busy       = (state_q != S_IDLE);
    assign fifo_count = count_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_hero_cmd_sched.sv
// tb/tb_hero_cmd_sched.sv - randomized and directed bench for hero_cmd_sched against a queue-based model
module tb_hero_cmd_sched;

    localparam int DEPTH       = 4;
    localparam int MOVE_BUSY   = 62;
    localparam int ATTACK_BUSY = 12;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_up, btn_left, btn_right, btn_down, btn_center;
    logic       enable, flush;
    logic       up, left, right, down, center, busy, overflow;
    logic [2:0] fifo_count;

    always #5 clk = ~clk;

    hero_cmd_sched #(
        .DEPTH       (DEPTH),
        .MOVE_BUSY   (MOVE_BUSY),
        .ATTACK_BUSY (ATTACK_BUSY)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_up     (btn_up),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_down   (btn_down),
        .btn_center (btn_center),
        .enable     (enable),
        .flush      (flush),
        .up         (up),
        .left       (left),
        .right      (right),
        .down       (down),
        .center     (center),
        .busy       (busy),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: queue of commands plus time of the last issued pulse
    int         mq[$];
    int         m_ovf;
    logic [4:0] m_prev;
    int         m_last_issue;
    int         m_last_busy;
    int         m_last_cmd;
    int         m_cyc = 0;
    logic       en_v;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d cycle=%0d", tag, got, exp, m_cyc);
        end
    endtask

    function automatic int busy_len(input int c);
        return (c == 4) ? ATTACK_BUSY : MOVE_BUSY;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ovf        = 0;
        m_prev       = '0;
        m_last_issue = -1000;
        m_last_busy  = MOVE_BUSY;
        m_last_cmd   = 0;
    endtask

    task automatic model_step(input logic [4:0] b, input logic e, input logic f);
        logic [4:0] pr;
        bit         can;
        int         c;
        pr     = b & ~m_prev;
        m_prev = b;
        can    = (m_cyc >= m_last_issue + m_last_busy - 1);
        if (f) begin
            mq.delete();
            m_ovf = 0;
        end else if (e) begin
            if (mq.size() > 0 && can) begin
                m_last_cmd   = mq.pop_front();
                m_last_issue = m_cyc + 1;
                m_last_busy  = busy_len(m_last_cmd);
            end
            if (pr != 0) begin
                c = 0;
                while (!pr[c]) c++;
                if (mq.size() < DEPTH) mq.push_back(c);
                else m_ovf = 1;
            end
        end
        m_cyc++;
    endtask

    task automatic check_outputs();
        logic [4:0] pv;
        int         exp_pulse;
        int         exp_busy;
        pv        = {center, down, right, left, up};
        exp_pulse = (m_cyc == m_last_issue) ? (1 << m_last_cmd) : 0;
        exp_busy  = (m_cyc >= m_last_issue && m_cyc <= m_last_issue + m_last_busy - 1) ? 1 : 0;
        check("pulses", int'(pv), exp_pulse);
        check("pulse_onehot", ($countones(pv) <= 1) ? 1 : 0, 1);
        check("busy", int'(busy), exp_busy);
        check("fifo_count", int'(fifo_count), mq.size());
        check("overflow", int'(overflow), m_ovf);
    endtask

    task automatic cycle(input logic [4:0] b, input logic e, input logic f);
        {btn_center, btn_down, btn_right, btn_left, btn_up} = b;
        enable = e;
        flush  = f;
        model_step(b, e, f);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(5'b0, en_v, 1'b0);
    endtask

    task automatic press(input logic [4:0] m);
        cycle(m, en_v, 1'b0);
        cycle(5'b0, en_v, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_pulses", int'({center, down, right, left, up}), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_count", int'(fifo_count), 0);
        check("rst_ovf", int'(overflow), 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_outputs();
    endtask

    initial begin
        logic [4:0] bs;
        logic       fl;
        rst = 1'b1;
        {btn_center, btn_down, btn_right, btn_left, btn_up} = '0;
        enable = 1'b1;
        flush  = 1'b0;
        en_v   = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check("init_pulses", int'({center, down, right, left, up}), 0);
        check("init_busy", int'(busy), 0);
        rst = 1'b0;
        check_outputs();

        // Single up press held for several cycles
        idle(10);
        repeat (3) cycle(5'b00001, 1'b1, 1'b0);
        idle(70);

        // Type-ahead until overflow
        press(5'b00001); idle(3);
        press(5'b00010); idle(3);
        press(5'b00100); idle(3);
        press(5'b01000); idle(3);
        press(5'b10000); idle(3);
        press(5'b00001);
        idle(62 * 4 + 20);
        cycle(5'b0, 1'b1, 1'b1);

        // Attack followed by move
        press(5'b10000); press(5'b00001); idle(80);

        // Simultaneous up and down
        press(5'b01001); idle(70);

        // Flush during WAIT
        press(5'b00001); press(5'b00010); press(5'b00100); press(5'b01000);
        idle(10);
        cycle(5'b0, 1'b1, 1'b1);
        idle(70);

        // Pause with entries queued, presses ignored, then resume and reset mid-WAIT
        press(5'b00001); press(5'b00010); press(5'b00100); idle(5);
        en_v = 1'b0;
        idle(40); press(5'b01000); idle(58);
        en_v = 1'b1;
        idle(30);
        do_reset();
        idle(80);

        // Random traffic
        bs = '0;
        for (int i = 0; i < 15000; i++) begin
            for (int k = 0; k < 5; k++)
                if ($urandom_range(0, 29) == 0) bs[k] = ~bs[k];
            if ($urandom_range(0, 199) == 0) en_v = ~en_v;
            fl = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 4999) == 0) do_reset();
            else cycle(bs, en_v, fl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
